// File: rtl/sd_sector_seq.sv
// rtl/sd_sector_seq.sv - CMD17/CMD24 single-sector sequencer over an SPI byte transceiver
module sd_sector_seq #(
   parameter int TIMEOUT_BYTES = 4095,
   parameter int BUSY_BYTES    = 65535
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        init_ok,
   input  logic        sdhc,
   input  logic        rd_req,
   input  logic        wr_req,
   input  logic [31:0] lba,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  errorno,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   input  logic [7:0]  wr_data,
   output logic        wr_next,
   output logic        cs_n,
   output logic        x_start,
   output logic [7:0]  x_tx,
   input  logic [7:0]  x_rx,
   input  logic        x_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_SYNC, S_CMD, S_R1, S_TOKEN, S_RDATA, S_RCRC,
      S_GAP, S_WTOKEN, S_WDATA, S_WCRC, S_DRESP, S_BUSYW, S_FINISH
   } state_t;

   localparam logic [16:0] TO_MAX   = 17'(TIMEOUT_BYTES);
   localparam logic [16:0] BUSY_MAX = 17'(BUSY_BYTES);

   state_t      state;
   logic        is_write;
   logic [31:0] arg;
   logic [2:0]  cmd_idx;
   logic [9:0]  byte_cnt;
   logic [16:0] poll_cnt;
   logic [7:0]  tx_q;

   function automatic logic [7:0] arg_byte(input logic [2:0] idx, input logic [31:0] a);
      case (idx)
         3'd1:    return a[31:24];
         3'd2:    return a[23:16];
         3'd3:    return a[15:8];
         3'd4:    return a[7:0];
         default: return 8'hFF;
      endcase
   endfunction

   // During a wr_next cycle the host byte goes straight out, then is held in tx_q.
   assign x_tx = wr_next ? wr_data : tx_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         cs_n     <= 1'b1;
         x_start  <= 1'b0;
         tx_q     <= 8'hFF;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         errorno  <= 8'd0;
         rd_data  <= 8'd0;
         rd_valid <= 1'b0;
         wr_next  <= 1'b0;
         is_write <= 1'b0;
         arg      <= 32'd0;
         cmd_idx  <= 3'd0;
         byte_cnt <= 10'd0;
         poll_cnt <= 17'd0;
      end else begin
         x_start  <= 1'b0;
         wr_next  <= 1'b0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
         if (wr_next)
            tx_q <= wr_data;
         // Every completed exchange in a waiting state launches the next one; FFh unless overridden.
         if (x_done && state != S_IDLE && state != S_START && state != S_FINISH) begin
            x_start <= 1'b1;
            tx_q    <= 8'hFF;
         end
         case (state)
            S_IDLE: if (rd_req || wr_req) begin
               if (!init_ok) begin
                  done    <= 1'b1;
                  error   <= 1'b1;
                  errorno <= 8'd7;
               end else begin
                  state    <= S_START;
                  busy     <= 1'b1;
                  cs_n     <= 1'b0;
                  error    <= 1'b0;
                  errorno  <= 8'd0;
                  is_write <= !rd_req;
                  arg      <= sdhc ? lba : {lba[22:0], 9'b0};
               end
            end
            S_START: begin
               state    <= S_SYNC;
               poll_cnt <= 17'd0;
               x_start  <= 1'b1;
               tx_q     <= 8'hFF;
            end
            S_SYNC: if (x_done) begin
               if (x_rx == 8'hFF) begin
                  state   <= S_CMD;
                  cmd_idx <= 3'd0;
                  tx_q    <= is_write ? 8'h58 : 8'h51;
               end else if (poll_cnt == TO_MAX) begin
                  state <= S_FINISH; error <= 1'b1; errorno <= 8'd1;
               end else
                  poll_cnt <= poll_cnt + 17'd1;
            end
            S_CMD: if (x_done) begin
               if (cmd_idx == 3'd5) begin
                  state    <= S_R1;
                  poll_cnt <= 17'd0;
               end else begin
                  cmd_idx <= cmd_idx + 3'd1;
                  tx_q    <= arg_byte(cmd_idx + 3'd1, arg);
               end
            end
            S_R1: if (x_done) begin
               if (!x_rx[7]) begin
                  if (x_rx != 8'h00) begin
                     state <= S_FINISH; error <= 1'b1; errorno <= 8'd3;
                  end else begin
                     state    <= is_write ? S_GAP : S_TOKEN;
                     poll_cnt <= 17'd0;
                  end
               end else if (poll_cnt == TO_MAX) begin
                  state <= S_FINISH; error <= 1'b1; errorno <= 8'd2;
               end else
                  poll_cnt <= poll_cnt + 17'd1;
            end
            S_TOKEN: if (x_done) begin
               if (x_rx == 8'hFE) begin
                  state    <= S_RDATA;
                  byte_cnt <= 10'd0;
               end else if (x_rx != 8'hFF || poll_cnt == TO_MAX) begin
                  state <= S_FINISH; error <= 1'b1; errorno <= 8'd4;
               end else
                  poll_cnt <= poll_cnt + 17'd1;
            end
            S_RDATA: if (x_done) begin
               rd_data  <= x_rx;
               rd_valid <= 1'b1;
               byte_cnt <= (byte_cnt == 10'd511) ? 10'd0 : byte_cnt + 10'd1;
               if (byte_cnt == 10'd511)
                  state <= S_RCRC;
            end
            S_RCRC: if (x_done) begin
               byte_cnt <= 10'd1;
               if (byte_cnt[0])
                  state <= S_FINISH;
            end
            S_GAP: if (x_done) begin
               state <= S_WTOKEN;
               tx_q  <= 8'hFE;
            end
            S_WTOKEN: if (x_done) begin
               state    <= S_WDATA;
               byte_cnt <= 10'd0;
               wr_next  <= 1'b1;
            end
            S_WDATA: if (x_done) begin
               if (byte_cnt == 10'd511) begin
                  state    <= S_WCRC;
                  byte_cnt <= 10'd0;
               end else begin
                  byte_cnt <= byte_cnt + 10'd1;
                  wr_next  <= 1'b1;
               end
            end
            S_WCRC: if (x_done) begin
               byte_cnt <= 10'd1;
               if (byte_cnt[0])
                  state <= S_DRESP;
            end
            S_DRESP: if (x_done) begin
               if (x_rx[4:0] == 5'b00101) begin
                  state    <= S_BUSYW;
                  poll_cnt <= 17'd0;
               end else begin
                  state <= S_FINISH; error <= 1'b1; errorno <= 8'd5;
               end
            end
            S_BUSYW: if (x_done) begin
               if (x_rx != 8'h00)
                  state <= S_FINISH;
               else if (poll_cnt == BUSY_MAX) begin
                  state <= S_FINISH; error <= 1'b1; errorno <= 8'd6;
               end else
                  poll_cnt <= poll_cnt + 17'd1;
            end
            S_FINISH: if (x_done) begin
               state <= S_IDLE;
               cs_n  <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_sector_seq.sv
// tb/tb_sd_sector_seq.sv - directed bench for sd_sector_seq with a byte-engine model
module tb_sd_sector_seq;

   localparam int TO = 20;
   localparam int BB = 40;

   logic        clock;
   logic        reset;
   logic        init_ok;
   logic        sdhc;
   logic        rd_req;
   logic        wr_req;
   logic [31:0] lba;
   logic        busy;
   logic        done;
   logic        error;
   logic [7:0]  errorno;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic [7:0]  wr_data;
   logic        wr_next;
   logic        cs_n;
   logic        x_start;
   logic [7:0]  x_tx;
   logic [7:0]  x_rx;
   logic        x_done;

   sd_sector_seq #(.TIMEOUT_BYTES(TO), .BUSY_BYTES(BB)) dut (
      .clock(clock), .reset(reset), .init_ok(init_ok), .sdhc(sdhc),
      .rd_req(rd_req), .wr_req(wr_req), .lba(lba), .busy(busy), .done(done),
      .error(error), .errorno(errorno), .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_data(wr_data), .wr_next(wr_next), .cs_n(cs_n), .x_start(x_start),
      .x_tx(x_tx), .x_rx(x_rx), .x_done(x_done)
   );

   initial clock = 1'b0;
   always #20 clock = ~clock;

   logic [7:0] rx_q[$];
   logic [7:0] tx_log[$];
   logic [7:0] rd_log[$];
   int         done_cnt = 0;
   int         prev_done = 0;
   int         wr_cnt = 0;
   int         wr_pulses = 0;
   bit         adv = 0;
   logic       last_busy, last_cs;
   logic [8:0] last_err;
   int         n_pass = 0;
   int         n_total = 0;

   function automatic logic [7:0] wdat(input int n);
      return 8'(n * 7 + 3);
   endfunction

   function automatic logic [63:0] tx_word(input int first, input int n);
      logic [63:0] w = 64'd0;
      for (int i = 0; i < n; i++)
         w = {w[55:0], (first + i < tx_log.size()) ? tx_log[first + i] : 8'hEE};
      return w;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Byte engine: answers each x_start two cycles later with the next scripted byte.
   initial begin
      x_done = 1'b0;
      x_rx   = 8'h00;
      forever begin
         @(negedge clock);
         x_done = 1'b0;
         if (x_start) begin
            tx_log.push_back(x_tx);
            @(negedge clock);
            @(negedge clock);
            x_rx   = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
            x_done = 1'b1;
         end
      end
   end

   // Host side: logs read data and done results, advances the write byte after each wr_next.
   initial begin
      forever begin
         @(negedge clock);
         if (done) begin
            done_cnt++;
            last_err  = {error, errorno};
            last_busy = busy;
            last_cs   = cs_n;
         end
         if (rd_valid) rd_log.push_back(rd_data);
         if (adv) begin
            wr_cnt++;
            wr_data = wdat(wr_cnt);
            adv = 0;
         end
         if (wr_next) begin
            adv = 1;
            wr_pulses++;
         end
      end
   end

   task automatic push_n(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) rx_q.push_back(b);
   endtask

   task automatic push_read();
      push_n(8'hFF, 7);
      rx_q.push_back(8'h00);
      rx_q.push_back(8'hFE);
      for (int i = 0; i < 512; i++) rx_q.push_back(8'(i));
      rx_q.push_back(8'hAA);
      rx_q.push_back(8'hBB);
      rx_q.push_back(8'hFF);
   endtask

   task automatic push_write(input logic [7:0] dresp, input bit busy_ok);
      push_n(8'hFF, 7);
      rx_q.push_back(8'h00);
      push_n(8'hFF, 2 + 512 + 2);
      rx_q.push_back(dresp);
      if (busy_ok) begin
         push_n(8'h00, 3);
         rx_q.push_back(8'hFF);
      end
      rx_q.push_back(8'hFF);
   endtask

   task automatic go(input logic rd, input logic wr, input logic [31:0] l, input logic s);
      tx_log.delete();
      rd_log.delete();
      wr_pulses = 0;
      wr_cnt    = 0;
      wr_data   = wdat(0);
      prev_done = done_cnt;
      @(negedge clock);
      rd_req = rd; wr_req = wr; lba = l; sdhc = s;
      @(negedge clock);
      rd_req = 1'b0; wr_req = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int i = 0;
      while (done_cnt == prev_done && i < limit) begin
         @(negedge clock);
         i++;
      end
      chk("done_count", done_cnt, prev_done + 1);
      chk("done_edge", {last_busy, last_cs}, 2'b01);
   endtask

   initial begin
      int errs;
      int i;
      reset = 1'b1; init_ok = 1'b0; sdhc = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
      lba = 32'd0; wr_data = 8'h00;
      repeat (3) @(negedge clock);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_busy", busy, 0);
      chk("rst_x_tx", x_tx, 8'hFF);
      chk("rst_err", {error, errorno}, 9'h000);
      chk("rst_pulses", {x_start, done, rd_valid, wr_next}, 4'b0000);
      chk("rst_rd_data", rd_data, 8'h00);
      reset = 1'b0;

      // Request without init: immediate error 7, no SPI traffic
      go(1'b1, 1'b0, 32'd0, 1'b1);
      chk("noinit_done", done, 1);
      chk("noinit_err", {error, errorno}, 9'h107);
      repeat (4) @(negedge clock);
      chk("noinit_tx", tx_log.size(), 0);
      chk("noinit_cs", cs_n, 1);
      init_ok = 1'b1;

      // Read, block addressing, lba 5
      push_read();
      go(1'b1, 1'b0, 32'd5, 1'b1);
      chk("acc_state", {busy, cs_n, x_start, error}, 4'b1000);
      @(negedge clock);
      chk("first_x_start", x_start, 1);
      wait_done(5000);
      chk("rd_cmd", tx_word(1, 6), 64'h0000_5100_0000_05FF);
      chk("rd_tx_len", tx_log.size(), 524);
      chk("rd_count", rd_log.size(), 512);
      errs = 0;
      for (int k = 0; k < rd_log.size(); k++) if (rd_log[k] !== 8'(k)) errs++;
      chk("rd_data", errs, 0);
      chk("rd_err", last_err, 9'h000);

      // Simultaneous requests (read wins), byte addressing lba 3, R1 = 04h
      push_n(8'hFF, 7);
      rx_q.push_back(8'h04);
      go(1'b1, 1'b1, 32'd3, 1'b0);
      wait_done(500);
      chk("r1bad_cmd", tx_word(1, 6), 64'h0000_5100_0006_00FF);
      chk("r1bad_tx_len", tx_log.size(), 9);
      chk("r1bad_err", last_err, 9'h103);

      // R1 never arrives: error 2 after TO+1 polls
      push_n(8'hFF, 7);
      go(1'b0, 1'b1, 32'd0, 1'b1);
      wait_done(2000);
      chk("r1to_tx_len", tx_log.size(), TO + 9);
      chk("r1to_err", last_err, 9'h102);

      // Write lba 1, response E5h, three busy bytes
      push_write(8'hE5, 1'b1);
      go(1'b0, 1'b1, 32'd1, 1'b1);
      chk("wr_acc_err_clr", {error, errorno}, 9'h000);
      wait_done(5000);
      chk("wr_cmd", tx_word(1, 6), 64'h0000_5800_0000_01FF);
      chk("wr_gap_tok", tx_word(8, 2), 64'h0000_0000_0000_FFFE);
      errs = 0;
      for (int k = 0; k < 512; k++)
         if (10 + k >= tx_log.size() || tx_log[10 + k] !== wdat(k)) errs++;
      chk("wr_data", errs, 0);
      chk("wr_crc", tx_word(522, 2), 64'h0000_0000_0000_FFFF);
      chk("wr_tx_len", tx_log.size(), 530);
      chk("wr_pulses", wr_pulses, 512);
      chk("wr_err", last_err, 9'h000);

      // Write rejected by data response 0Bh
      push_write(8'h0B, 1'b0);
      go(1'b0, 1'b1, 32'd9, 1'b1);
      wait_done(5000);
      chk("wrbad_err", last_err, 9'h105);
      chk("wrbad_tx_len", tx_log.size(), 526);
      chk("wrbad_pulses", wr_pulses, 512);

      // Reset in the middle of read data
      push_read();
      go(1'b1, 1'b0, 32'd5, 1'b1);
      i = 0;
      while (rd_log.size() < 100 && i < 3000) begin
         @(negedge clock);
         i++;
      end
      chk("mid_reached", rd_log.size() >= 100, 1);
      reset = 1'b1;
      @(negedge clock);
      chk("mid_rst_out", {cs_n, busy, x_start, done, rd_valid}, 5'b10000);
      reset = 1'b0;
      repeat (10) @(negedge clock);
      chk("mid_no_done", done_cnt, prev_done);
      chk("mid_idle", {cs_n, busy}, 2'b10);
      rx_q.delete();

      // Normal read after the aborted one
      push_read();
      go(1'b1, 1'b0, 32'd5, 1'b1);
      wait_done(5000);
      chk("post_rd_count", rd_log.size(), 512);
      chk("post_rd_err", last_err, 9'h000);
      chk("post_rd_cmd", tx_word(1, 6), 64'h0000_5100_0000_05FF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
